// File: rtl/cnn_pkg.sv
// rtl/cnn_pkg.sv - shared sizes, address widths and FSM state encoding for the convolution read controller
//
// Purpose: one place for the default vector/filter lengths, the derived
// output count and the widths of every address/counter used by the
// convolution read path.
package cnn_pkg;

  // Default input vector length (x memory depth).
  localparam int N_LEN   = 43;
  // Default filter length (f memory depth).
  localparam int M_LEN   = 16;
  // Number of valid convolution outputs at the defaults.
  localparam int O_LEN   = N_LEN - M_LEN + 1;

  // x memory address width (covers 0..N_LEN-1).
  localparam int XADDR_W = 6;
  // f memory address width (covers 0..M_LEN-1).
  localparam int FADDR_W = 4;
  // Output index j width (covers 0..O_LEN-1).
  localparam int J_W     = 5;
  // Filter tap index k width (covers 0..M_LEN-1).
  localparam int K_W     = 4;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    RUN   = 3'd2,
    DRAIN = 3'd3,
    OUT   = 3'd4
  } state_t;

endpackage

// File: rtl/ctrl_conv_read.sv
// rtl/ctrl_conv_read.sv - read sequencer for a sliding-window 1-D convolution engine
//
// Purpose: for each output j = 0..O-1, points the x address counter at j,
// walks the M filter taps (x at j+k, f at k), lets the MAC accumulate with a
// one-cycle lag for the synchronous RAM read, waits for the last product to
// land, then presents the result on a valid/ready handshake.
//
// Ports:
//   clk               in   rising-edge clock
//   reset             in   synchronous, active-high
//   x_loaded          in   x memory holds all N words
//   f_loaded          in   f memory holds all M words
//   en_ext_ctrl       out  this block owns the x address counter
//   ext_load_addr     out  load x address counter with ext_load_addr_val
//   ext_load_addr_val out  window start address j
//   ext_incr_addr     out  increment x address counter
//   f_addr            out  filter read address k
//   mac_clr           out  clear MAC accumulator
//   mac_en            out  accumulate current x*f product
//   m_valid           out  result j available
//   m_ready           in   downstream accepts result
//   conv_done         out  one-cycle pulse after the last result is accepted
module ctrl_conv_read
  import cnn_pkg::*;
#(
  parameter int N = N_LEN,
  parameter int M = M_LEN
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               x_loaded,
  input  logic               f_loaded,
  output logic               en_ext_ctrl,
  output logic               ext_load_addr,
  output logic [XADDR_W-1:0] ext_load_addr_val,
  output logic               ext_incr_addr,
  output logic [FADDR_W-1:0] f_addr,
  output logic               mac_clr,
  output logic               mac_en,
  output logic               m_valid,
  input  logic               m_ready,
  output logic               conv_done
);

  localparam int O = N - M + 1;

  localparam logic [J_W-1:0] J_LAST = J_W'(O - 1);
  localparam logic [K_W-1:0] K_LAST = K_W'(M - 1);

  state_t         state_q, state_d;
  logic [J_W-1:0] j_q, j_d;
  logic [K_W-1:0] k_q, k_d;
  // Second-cycle marker for the two-cycle drain.
  logic           drain_q, drain_d;
  logic           mac_en_q;
  logic           conv_done_q, conv_done_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      j_q         <= '0;
      k_q         <= '0;
      drain_q     <= 1'b0;
      mac_en_q    <= 1'b0;
      conv_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      j_q         <= j_d;
      k_q         <= k_d;
      drain_q     <= drain_d;
      // The RAM data for the tap addressed in RUN cycle k arrives one cycle
      // later, so the accumulate strobe is RUN delayed by one.
      mac_en_q    <= (state_q == RUN);
      conv_done_q <= conv_done_d;
    end
  end

  always_comb begin
    state_d           = state_q;
    j_d               = j_q;
    k_d               = k_q;
    drain_d           = drain_q;
    conv_done_d       = 1'b0;
    en_ext_ctrl       = 1'b0;
    ext_load_addr     = 1'b0;
    ext_load_addr_val = '0;
    ext_incr_addr     = 1'b0;
    f_addr            = '0;
    mac_clr           = 1'b0;
    m_valid           = 1'b0;

    unique case (state_q)
      IDLE: begin
        j_d = '0;
        k_d = '0;
        if (x_loaded && f_loaded) begin
          state_d = LOAD;
        end
      end

      LOAD: begin
        en_ext_ctrl       = 1'b1;
        ext_load_addr     = 1'b1;
        ext_load_addr_val = XADDR_W'(j_q);
        mac_clr           = 1'b1;
        k_d               = '0;
        state_d           = RUN;
      end

      RUN: begin
        en_ext_ctrl = 1'b1;
        f_addr      = FADDR_W'(k_q);
        if (k_q == K_LAST) begin
          // Last tap: the x counter already sits on j+M-1, so no further
          // increment and no address past N-1.
          drain_d = 1'b0;
          state_d = DRAIN;
        end else begin
          ext_incr_addr = 1'b1;
          k_d           = k_q + K_W'(1);
        end
      end

      DRAIN: begin
        // First cycle: last product being accumulated.
        // Second cycle: accumulator settled.
        en_ext_ctrl = 1'b1;
        if (drain_q) begin
          state_d = OUT;
        end else begin
          drain_d = 1'b1;
        end
      end

      OUT: begin
        en_ext_ctrl = 1'b1;
        m_valid     = 1'b1;
        if (m_ready) begin
          if (j_q == J_LAST) begin
            j_d         = '0;
            conv_done_d = 1'b1;
            state_d     = IDLE;
          end else begin
            j_d     = j_q + J_W'(1);
            state_d = LOAD;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign mac_en    = mac_en_q;
  assign conv_done = conv_done_q;

endmodule

// File: tb/tb_ctrl_conv_read.sv
// tb/tb_ctrl_conv_read.sv - self-checking bench for ctrl_conv_read
module tb_ctrl_conv_read;

  localparam int N = 43;
  localparam int M = 16;
  localparam int O = N - M + 1;

  logic       clk = 1'b0;
  logic       reset;
  logic       x_loaded;
  logic       f_loaded;
  logic       en_ext_ctrl;
  logic       ext_load_addr;
  logic [5:0] ext_load_addr_val;
  logic       ext_incr_addr;
  logic [3:0] f_addr;
  logic       mac_clr;
  logic       mac_en;
  logic       m_valid;
  logic       m_ready;
  logic       conv_done;

  ctrl_conv_read #(.N(N), .M(M)) dut (
    .clk               (clk),
    .reset             (reset),
    .x_loaded          (x_loaded),
    .f_loaded          (f_loaded),
    .en_ext_ctrl       (en_ext_ctrl),
    .ext_load_addr     (ext_load_addr),
    .ext_load_addr_val (ext_load_addr_val),
    .ext_incr_addr     (ext_incr_addr),
    .f_addr            (f_addr),
    .mac_clr           (mac_clr),
    .mac_en            (mac_en),
    .m_valid           (m_valid),
    .m_ready           (m_ready),
    .conv_done         (conv_done)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Environment: memories, x address counter, 1-cycle RAM and MAC.
  int x_mem [0:N-1];
  int f_mem [0:M-1];
  int xaddr = 0;
  int x_rd = 0, f_rd = 0, rd_addr = 0, f_idx_rd = 0;
  int acc = 0, mac_cnt = 0, hi = -1, base = 0;
  bit f_ok = 1'b1, x_ok = 1'b1;

  always @(posedge clk) begin
    if (en_ext_ctrl) begin
      if (ext_load_addr) xaddr <= int'(ext_load_addr_val);
      else if (ext_incr_addr) xaddr <= xaddr + 1;
    end
    x_rd     <= (xaddr >= 0 && xaddr < N) ? x_mem[xaddr] : 32'h0bad0bad;
    rd_addr  <= xaddr;
    f_rd     <= f_mem[f_addr];
    f_idx_rd <= int'(f_addr);
    if (mac_clr) begin
      acc <= 0; mac_cnt <= 0; hi <= -1; f_ok <= 1'b1; x_ok <= 1'b1;
      base <= int'(ext_load_addr_val);
    end else if (mac_en) begin
      acc     <= acc + x_rd * f_rd;
      mac_cnt <= mac_cnt + 1;
      if (rd_addr > hi) hi <= rd_addr;
      if (f_idx_rd != mac_cnt) f_ok <= 1'b0;
      if (rd_addr != base + mac_cnt) x_ok <= 1'b0;
    end
  end

  function automatic int exp_sum(input int j);
    int s = 0;
    for (int k = 0; k < M; k++) s += x_mem[j + k] * f_mem[k];
    return s;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    reset = 1'b1; x_loaded = 1'b0; f_loaded = 1'b0; m_ready = 1'b0;
    tick(); tick();
    reset = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_en"},    en_ext_ctrl, 0);
    check({tag, "_ld"},    ext_load_addr, 0);
    check({tag, "_lav"},   ext_load_addr_val, 0);
    check({tag, "_incr"},  ext_incr_addr, 0);
    check({tag, "_faddr"}, f_addr, 0);
    check({tag, "_clr"},   mac_clr, 0);
    check({tag, "_macen"}, mac_en, 0);
    check({tag, "_valid"}, m_valid, 0);
    check({tag, "_done"},  conv_done, 0);
  endtask

  // mode 0: always ready; 1: ready held low 10 cycles at j=5; 2: random ready
  task automatic run_conv(input int mode, input bit golden);
    int  j_exp = 0, t_load = -1000, t_hs = -1000, stall = 0, done_cnt = 0, budget = 0;
    bit  prev_hold = 1'b0, done_seen = 1'b0;
    x_loaded = 1'b1; f_loaded = 1'b1; m_ready = 1'b1;
    while (!done_seen && budget < 3000) begin
      tick(); budget++;
      if (conv_done) done_cnt++;
      if (prev_hold) begin
        check("hold_valid",   m_valid, 1);
        check("hold_no_incr", ext_incr_addr, 0);
        check("hold_no_load", ext_load_addr, 0);
      end
      if (j_exp == O) begin
        check("done_pulse", conv_done, 1);
        check("done_idle_en", en_ext_ctrl, 0);
        tick();
        check("done_single", conv_done, 0);
        done_seen = 1'b1;
      end else begin
        if (ext_load_addr) begin
          check("load_j", ext_load_addr_val, j_exp);
          t_load = cyc;
        end
        if (m_valid && !prev_hold) check("latency", cyc - t_load, M + 3);
        if (mode == 2) m_ready = 1'($urandom_range(0, 1));
        else if (mode == 1 && m_valid && j_exp == 5 && stall < 10) begin
          m_ready = 1'b0; stall++;
        end else m_ready = 1'b1;
        prev_hold = m_valid && !m_ready;
        if (m_valid && m_ready) begin
          check("result",  acc, exp_sum(j_exp));
          check("mac_cnt", mac_cnt, M);
          check("hi_addr", hi, j_exp + M - 1);
          check("f_order", int'(f_ok), 1);
          check("x_order", int'(x_ok), 1);
          if (golden && j_exp == 0)     check("golden_first", acc, 136);
          if (golden && j_exp == O - 1) check("golden_last",  acc, 568);
          if (mode == 0 && j_exp > 0)   check("spacing", cyc - t_hs, 20);
          t_hs = cyc;
          j_exp++;
        end
      end
    end
    if (!done_seen) check("run_timeout", 0, 1);
    check("done_count", done_cnt, 1);
    if (mode == 1) check("stall_applied", stall, 10);
  endtask

  typedef struct {
    bit xl;
    bit fl;
    bit exp_en;
  } gate_vec_t;

  typedef struct {
    int off;
    bit en;
    bit ld;
    int lav;
    bit incr;
    int fa;
    bit clr;
    bit me;
    bit mv;
  } tim_vec_t;

  gate_vec_t gv [4];
  tim_vec_t  tv [9];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    gv[0] = '{1'b0, 1'b0, 1'b0};
    gv[1] = '{1'b1, 1'b0, 1'b0};
    gv[2] = '{1'b0, 1'b1, 1'b0};
    gv[3] = '{1'b1, 1'b1, 1'b1};

    //         off en ld lav incr fa clr me mv
    tv[0] = '{ 0, 1, 1, 0, 0,  0, 1, 0, 0};
    tv[1] = '{ 1, 1, 0, 0, 1,  0, 0, 0, 0};
    tv[2] = '{ 2, 1, 0, 0, 1,  1, 0, 1, 0};
    tv[3] = '{ 8, 1, 0, 0, 1,  7, 0, 1, 0};
    tv[4] = '{15, 1, 0, 0, 1, 14, 0, 1, 0};
    tv[5] = '{16, 1, 0, 0, 0, 15, 0, 1, 0};
    tv[6] = '{17, 1, 0, 0, 0,  0, 0, 1, 0};
    tv[7] = '{19, 1, 0, 0, 0,  0, 0, 0, 1};
    tv[8] = '{20, 1, 1, 1, 0,  0, 1, 0, 0};

    for (int i = 0; i < N; i++) x_mem[i] = i + 1;
    for (int i = 0; i < M; i++) f_mem[i] = 1;

    // Reset state
    do_reset();
    check_all_zero("reset");

    // IDLE gating: start only when both memories are loaded
    for (int i = 0; i < 4; i++) begin
      do_reset();
      x_loaded = gv[i].xl; f_loaded = gv[i].fl; m_ready = 1'b1;
      tick(); tick();
      check("gate_en", en_ext_ctrl, int'(gv[i].exp_en));
      tick(); tick(); tick();
      check("gate_en_late", en_ext_ctrl, int'(gv[i].exp_en));
    end

    // Cycle-accurate timing of the first window
    do_reset();
    x_loaded = 1'b1; f_loaded = 1'b1; m_ready = 1'b1;
    tick();
    begin
      int cur = 0;
      for (int i = 0; i < 9; i++) begin
        while (cur < tv[i].off) begin tick(); cur++; end
        check("t_en",    en_ext_ctrl,       int'(tv[i].en));
        check("t_ld",    ext_load_addr,     int'(tv[i].ld));
        check("t_lav",   ext_load_addr_val, tv[i].lav);
        check("t_incr",  ext_incr_addr,     int'(tv[i].incr));
        check("t_faddr", f_addr,            tv[i].fa);
        check("t_clr",   mac_clr,           int'(tv[i].clr));
        check("t_macen", mac_en,            int'(tv[i].me));
        check("t_valid", m_valid,           int'(tv[i].mv));
      end
    end

    // Full golden run, always ready
    do_reset();
    run_conv(0, 1'b1);

    // Back-pressure for 10 cycles at j=5
    do_reset();
    run_conv(1, 1'b0);

    // Reset at RUN k=7 of j=3, then restart from j=0
    do_reset();
    x_loaded = 1'b1; f_loaded = 1'b1; m_ready = 1'b1;
    begin
      int  budget = 0;
      bit  found = 1'b0;
      while (!found && budget < 200) begin
        tick(); budget++;
        if (ext_load_addr && ext_load_addr_val == 6'd3) found = 1'b1;
      end
      check("find_j3", int'(found), 1);
    end
    for (int i = 0; i < 8; i++) tick();
    check("mid_k7_faddr", f_addr, 7);
    reset = 1'b1;
    tick();
    check_all_zero("midreset");
    reset = 1'b0;
    tick();
    check("restart_ld",  ext_load_addr, 1);
    check("restart_lav", ext_load_addr_val, 0);
    do_reset();

    // Random data with random back-pressure
    for (int i = 0; i < N; i++) x_mem[i] = int'($urandom_range(0, 255));
    for (int i = 0; i < M; i++) f_mem[i] = int'($urandom_range(0, 255));
    do_reset();
    run_conv(2, 1'b0);
    do_reset();
    check_all_zero("final");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ctrl_conv_read.md
CTRL_CONV_READ -- requirements
Module: ctrl_conv_read

Interface
REQ-001 SHALL have parameter N, default 43, input vector length (x memory depth).
REQ-002 SHALL have parameter M, default 16, filter length (f memory depth).
REQ-003 SHALL derive localparam O = N-M+1 (28), number of convolution outputs.
REQ-004 SHALL use a single clock, clk; reset is synchronous and active-high.
REQ-005 clk  input  1  rising-edge clock.
REQ-006 reset  input  1  synchronous, active-high.
REQ-007 x_loaded  input  1  x memory holds all N words.
REQ-008 f_loaded  input  1  f memory holds all M words.
REQ-009 en_ext_ctrl  output  1  hands x-memory address counter to this block.
REQ-010 ext_load_addr  output  1  loads x address counter with ext_load_addr_val.
REQ-011 ext_load_addr_val  output  6  window start address j.
REQ-012 ext_incr_addr  output  1  increments x address counter.
REQ-013 f_addr  output  4  filter read address.
REQ-014 mac_clr  output  1  clears MAC accumulator.
REQ-015 mac_en  output  1  accumulates current x*f product.
REQ-016 m_valid  output  1  AXI-stream master valid, result j available.
REQ-017 m_ready  input  1  AXI-stream slave ready.
REQ-018 conv_done  output  1  one-cycle pulse after output O-1 accepted.

Function
REQ-019 FSM states SHALL be IDLE, LOAD, RUN, DRAIN, OUT.
REQ-020 IDLE: all outputs 0; when x_loaded & f_loaded both 1 -> LOAD with j=0; inputs sampled only in IDLE.
REQ-021 LOAD (1 cycle): en_ext_ctrl=1, ext_load_addr=1, ext_load_addr_val=j, mac_clr=1, f_addr=0, k=0 -> RUN.
REQ-022 RUN (M cycles, k=0..M-1): en_ext_ctrl=1, f_addr=k, ext_incr_addr=1 for k<M-1, 0 at k=M-1; x counter thus equals j+k in RUN cycle k.
REQ-023 RUN k=M-1 -> DRAIN; DRAIN SHALL last exactly 2 cycles, then -> OUT.
REQ-024 mac_en SHALL equal (state==RUN) delayed one cycle (1-cycle synchronous RAM read latency); high for exactly M cycles per output.
REQ-025 en_ext_ctrl SHALL be 1 in LOAD, RUN, DRAIN, OUT; 0 in IDLE.
REQ-026 OUT: m_valid=1, held stable until m_valid & m_ready on a rising edge; m_ready while m_valid=0 has no effect.
REQ-027 On OUT handshake with j<O-1: j<=j+1 -> LOAD.
REQ-028 On OUT handshake with j=O-1: conv_done=1 for next cycle only, j<=0 -> IDLE.
REQ-029 Latency from LOAD entry to m_valid SHALL be M+3 cycles (19 at defaults); no back-to-back output overlap.
REQ-030 j SHALL be 5 bits saturating never past O-1; k SHALL be 4 bits, no wrap beyond M-1.
REQ-031 Maximum address driven SHALL be j+M-1 = N-1 (42); no out-of-range read.

Reset
REQ-032 Reset SHALL force IDLE, j=0, k=0, and all outputs 0 on the next edge, including mid-RUN or mid-OUT (pending result discarded, m_valid dropped).
REQ-033 Reset SHALL take priority over every other transition.

Structure
REQ-034 N, M, O, address widths and the state enum SHALL live in shared package cnn_pkg.
REQ-035 FSM and counters SHALL be one module; no sub-module.
REQ-036 All outputs SHALL be registered or decoded from registered state only; no input-to-output combinational path.

Verification
REQ-037 x_loaded=f_loaded=1, m_ready=1 -> 28 m_valid handshakes, each 20 cycles apart, conv_done single pulse after 28th.
REQ-038 Observed x addresses for output j=5 -> 5..20 in RUN, f_addr 0..15, mac_en 16 cycles lagging by one.
REQ-039 m_ready held 0 for 10 cycles in OUT -> m_valid stays 1, no address activity, j unchanged.
REQ-040 Only x_loaded=1 -> block stays IDLE, en_ext_ctrl=0.
REQ-041 reset asserted at RUN k=7 of j=3 -> next cycle IDLE, all outputs 0; restart produces j=0 first.
REQ-042 Golden model: x=1..43, f=all 1 -> accumulator results equal sum(x[j..j+15]), first 136, last 568.
